anton_neopixel_stream_logic: RTL

Sequencer that drives the bit-stream stage of the NeoPixel controller. It generates the transmit/reset state, current pixel index, bit-within-pixel index and bit-pattern slot index. The downstream stream stage turns these into the serial `neoData` waveform. It also closes each frame with the latch (reset) low period, emits a frame-sync pulse, and clears the run bit after a single-shot frame.

---
 rtl/anton_neopixel_stream_logic.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/anton_neopixel_stream_logic.sv
// anton_neopixel_stream_logic: bit-stream sequencer for the NeoPixel controller.
// Walks pixel/bit/pattern-slot indices while transmitting, then holds the latch low period.
`default_nettype none

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef ENUM_STATE_RESET
`define ENUM_STATE_RESET 1'b0
`endif
`ifndef ENUM_STATE_TRANSMIT
`define ENUM_STATE_TRANSMIT 1'b1
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module anton_neopixel_stream_logic #(
  parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
  parameter int RESET_DELAY  = 400,
  localparam int BUFFER_BITS = `CLOG2(BUFFER_END+1)
) (
  input  logic                   clk7mhz,
  input  logic                   syncRstN,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_loop,
  input  logic                   reg_ctrl_32bit,
  input  logic [BUFFER_BITS-1:0] reg_max,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixel_index,
  output logic [4:0]             pixel_bit_index,
  output logic [2:0]             bit_pattern_index,
  output logic                   stream_sync,
  output logic                   reg_ctrl_run_clear
);

  localparam int CNT_BITS = (RESET_DELAY > 2) ? $clog2(RESET_DELAY) : 1;
  localparam logic [CNT_BITS-1:0]  RD_LAST = CNT_BITS'(RESET_DELAY - 1);
  localparam logic [CNT_BITS-1:0]  RD_PRE  = CNT_BITS'(RESET_DELAY - 2);
  localparam logic [BUFFER_BITS:0] END_V   = (BUFFER_BITS+1)'(BUFFER_END);

  typedef enum logic {
    ST_RESET    = `ENUM_STATE_RESET,
    ST_TRANSMIT = `ENUM_STATE_TRANSMIT
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   frame_sent_q, frame_sent_d;
  logic                   mode32_q, mode32_d;
  logic [BUFFER_BITS-1:0] max_q, max_d;
  logic [BUFFER_BITS-1:0] pix_q, pix_d;
  logic [4:0]             bit_q, bit_d;
  logic [2:0]             pat_q, pat_d;
  logic                   sync_q, sync_d;
  logic                   clear_q, clear_d;

  logic [BUFFER_BITS-1:0] step;
  logic                   last_pixel;
  logic                   pixel_done;

  always_ff @(posedge clk7mhz) begin
    if (!syncRstN) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      frame_sent_q <= 1'b0;
      mode32_q     <= 1'b0;
      max_q        <= '0;
      pix_q        <= '0;
      bit_q        <= 5'd23;
      pat_q        <= 3'd0;
      sync_q       <= 1'b0;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_sent_q <= frame_sent_d;
      mode32_q     <= mode32_d;
      max_q        <= max_d;
      pix_q        <= pix_d;
      bit_q        <= bit_d;
      pat_q        <= pat_d;
      sync_q       <= sync_d;
      clear_q      <= clear_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_sent_d = frame_sent_q;
    mode32_d     = mode32_q;
    max_d        = max_q;
    pix_d        = pix_q;
    bit_d        = bit_q;
    pat_d        = pat_q;
    sync_d       = 1'b0;
    clear_d      = 1'b0;

    step       = mode32_q ? BUFFER_BITS'(4) : BUFFER_BITS'(1);
    // The overflow guard stops a frame before the index could run past the buffer.
    last_pixel = (mode32_q ? (pix_q[BUFFER_BITS-1:2] == max_q[BUFFER_BITS-1:2])
                           : (pix_q == max_q))
               || (({1'b0, pix_q} + {1'b0, step}) > END_V);
    pixel_done = (pat_q == 3'd7) && (bit_q == 5'd0);

    case (state_q)
      ST_RESET: begin
        if (cnt_q == RD_LAST) begin
          cnt_d = '0;
          // The clear pulse is on the output this cycle, so it decides the branch.
          if (clear_q) begin
            frame_sent_d = 1'b0;
          end else if (reg_ctrl_run) begin
            state_d  = ST_TRANSMIT;
            mode32_d = reg_ctrl_32bit;
            max_d    = reg_max;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Registered pulses are launched one cycle early to land in the final latch cycle.
          if (cnt_q == RD_PRE) begin
            sync_d  = 1'b1;
            clear_d = frame_sent_q && !reg_ctrl_loop;
          end
        end
      end

      ST_TRANSMIT: begin
        pat_d = pat_q + 3'd1;
        if ((pixel_done && last_pixel) || !reg_ctrl_run) begin
          state_d      = ST_RESET;
          cnt_d        = '0;
          pix_d        = '0;
          bit_d        = 5'd23;
          pat_d        = 3'd0;
          frame_sent_d = frame_sent_q || (pixel_done && last_pixel);
        end else if (pat_q == 3'd7) begin
          if (bit_q == 5'd0) begin
            bit_d = 5'd23;
            pix_d = pix_q + step;
          end else begin
            bit_d = bit_q - 5'd1;
          end
        end
      end

      default: state_d = ST_RESET;
    endcase
  end

  assign state              = state_q;
  assign pixel_index        = pix_q;
  assign pixel_bit_index    = bit_q;
  assign bit_pattern_index  = pat_q;
  assign stream_sync        = sync_q;
  assign reg_ctrl_run_clear = clear_q;

endmodule

`default_nettype wire
